// File: rtl/issue_queue.sv
// Age-ordered issue queue: dispatch up to SS ops/cycle, CDB wakeup with dispatch
// bypass, oldest-first select onto NUM_ISSUE function units, full flush.
module issue_queue #(
    parameter int SS        = 2,
    parameter int DEPTH     = 8,
    parameter int NUM_ISSUE = 2,
    parameter int NUM_CDB   = 2,
    parameter int ROB_ID_W  = 5,
    parameter int PAYLOAD_W = 64,
    parameter int TYPE_W    = 2,
    parameter logic [TYPE_W-1:0] FU_TYPE = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SS-1:0]                  disp_valid,
    input  logic [SS*TYPE_W-1:0]           disp_type,
    input  logic [SS*ROB_ID_W-1:0]         disp_rob_id,
    input  logic [SS*ROB_ID_W-1:0]         disp_src1_tag,
    input  logic [SS-1:0]                  disp_src1_rdy,
    input  logic [SS*ROB_ID_W-1:0]         disp_src2_tag,
    input  logic [SS-1:0]                  disp_src2_rdy,
    input  logic [SS*PAYLOAD_W-1:0]        disp_payload,
    output logic                           disp_stall,
    input  logic [NUM_CDB-1:0]             cdb_valid,
    input  logic [NUM_CDB*ROB_ID_W-1:0]    cdb_tag,
    input  logic [NUM_ISSUE-1:0]           fu_ready,
    input  logic                           flush,
    output logic [NUM_ISSUE-1:0]           issue_valid,
    output logic [NUM_ISSUE*ROB_ID_W-1:0]  issue_rob_id,
    output logic [NUM_ISSUE*PAYLOAD_W-1:0] issue_payload,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]     valid_q, s1_rdy_q, s2_rdy_q, s1_rdy_n, s2_rdy_n;
    logic [ROB_ID_W-1:0]  rob_q [DEPTH];
    logic [ROB_ID_W-1:0]  s1_tag_q [DEPTH];
    logic [ROB_ID_W-1:0]  s2_tag_q [DEPTH];
    logic [PAYLOAD_W-1:0] pay_q [DEPTH];
    // age_q[i][j] = 1 when entry i is older than entry j
    logic [DEPTH-1:0]     age_q [DEPTH];
    logic [DEPTH-1:0]     age_n [DEPTH];
    logic [OCC_W-1:0]     occ_q, num_acc, num_iss;

    logic [SS-1:0]        accept;
    logic [DEPTH-1:0]     alloc_oh [SS];
    logic [DEPTH-1:0]     alloc_any, used, eligible, taken, cand, bit_i;
    logic                 found;
    logic [NUM_ISSUE-1:0] sel_valid;
    logic [ROB_ID_W-1:0]  sel_rob [NUM_ISSUE];
    logic [PAYLOAD_W-1:0] sel_pay [NUM_ISSUE];

    function automatic logic cdb_hit(input logic [ROB_ID_W-1:0] tag,
                                     input logic [NUM_CDB-1:0] cv,
                                     input logic [NUM_CDB*ROB_ID_W-1:0] ct);
        logic hit;
        hit = 1'b0;
        for (int unsigned c = 0; c < NUM_CDB; c++)
            if (cv[c] && ct[c*ROB_ID_W +: ROB_ID_W] == tag) hit = 1'b1;
        return hit;
    endfunction

    assign disp_stall = (DEPTH - int'(occ_q)) < SS;
    assign occupancy  = occ_q;

    // Accepted lanes take the lowest free entries in lane order; entries
    // freed by this cycle's issue are not reused until next cycle.
    always_comb begin
        accept    = '0;
        used      = '0;
        alloc_any = '0;
        num_acc   = '0;
        found     = 1'b0;
        for (int unsigned k = 0; k < SS; k++) begin
            alloc_oh[k] = '0;
            accept[k]   = disp_valid[k] && disp_type[k*TYPE_W +: TYPE_W] == FU_TYPE
                          && !disp_stall && !flush;
            found = 1'b0;
            if (accept[k]) begin
                num_acc = num_acc + OCC_W'(1);
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (!valid_q[i] && !used[i] && !found) begin
                        alloc_oh[k][i] = 1'b1;
                        used[i]        = 1'b1;
                        found          = 1'b1;
                    end
                end
            end
            alloc_any = alloc_any | alloc_oh[k];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            age_n[i]    = age_q[i];
            s1_rdy_n[i] = s1_rdy_q[i] | cdb_hit(s1_tag_q[i], cdb_valid, cdb_tag);
            s2_rdy_n[i] = s2_rdy_q[i] | cdb_hit(s2_tag_q[i], cdb_valid, cdb_tag);
        end
        // Later lanes overwrite earlier ones, so a lower lane ends up older.
        for (int unsigned k = 0; k < SS; k++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (alloc_oh[k][i]) begin
                    s1_rdy_n[i] = disp_src1_rdy[k] |
                        cdb_hit(disp_src1_tag[k*ROB_ID_W +: ROB_ID_W], cdb_valid, cdb_tag);
                    s2_rdy_n[i] = disp_src2_rdy[k] |
                        cdb_hit(disp_src2_tag[k*ROB_ID_W +: ROB_ID_W], cdb_valid, cdb_tag);
                    age_n[i] = '0;
                    for (int unsigned j = 0; j < DEPTH; j++)
                        if (j != i) age_n[j][i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        eligible  = valid_q & s1_rdy_q & s2_rdy_q;
        taken     = '0;
        sel_valid = '0;
        num_iss   = '0;
        cand      = '0;
        bit_i     = '0;
        for (int unsigned p = 0; p < NUM_ISSUE; p++) begin
            sel_rob[p] = '0;
            sel_pay[p] = '0;
            cand = eligible & ~taken;
            if (fu_ready[p]) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    bit_i = DEPTH'(1) << i;
                    if (cand[i] && !sel_valid[p] && ((cand & ~age_q[i] & ~bit_i) == '0)) begin
                        sel_valid[p] = 1'b1;
                        sel_rob[p]   = rob_q[i];
                        sel_pay[p]   = pay_q[i];
                        taken        = taken | bit_i;
                    end
                end
            end
            if (sel_valid[p]) num_iss = num_iss + OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            occ_q         <= '0;
            issue_valid   <= '0;
            issue_rob_id  <= '0;
            issue_payload <= '0;
        end else if (flush) begin
            valid_q     <= '0;
            occ_q       <= '0;
            issue_valid <= '0;
        end else begin
            valid_q  <= (valid_q & ~taken) | alloc_any;
            s1_rdy_q <= s1_rdy_n;
            s2_rdy_q <= s2_rdy_n;
            age_q    <= age_n;
            occ_q    <= occ_q + num_acc - num_iss;
            for (int unsigned k = 0; k < SS; k++) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (alloc_oh[k][i]) begin
                        rob_q[i]    <= disp_rob_id[k*ROB_ID_W +: ROB_ID_W];
                        s1_tag_q[i] <= disp_src1_tag[k*ROB_ID_W +: ROB_ID_W];
                        s2_tag_q[i] <= disp_src2_tag[k*ROB_ID_W +: ROB_ID_W];
                        pay_q[i]    <= disp_payload[k*PAYLOAD_W +: PAYLOAD_W];
                    end
                end
            end
            issue_valid <= sel_valid;
            for (int unsigned p = 0; p < NUM_ISSUE; p++) begin
                if (sel_valid[p]) begin
                    issue_rob_id[p*ROB_ID_W +: ROB_ID_W]    <= sel_rob[p];
                    issue_payload[p*PAYLOAD_W +: PAYLOAD_W] <= sel_pay[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: dispatch/issue latency, wakeup, bypass,
// stall boundary, age ordering across entry reuse, flush and mid-run reset.
module tb_issue_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   disp_valid;
    logic [3:0]   disp_type;
    logic [9:0]   disp_rob_id, disp_src1_tag, disp_src2_tag;
    logic [1:0]   disp_src1_rdy, disp_src2_rdy;
    logic [127:0] disp_payload;
    logic         disp_stall;
    logic [1:0]   cdb_valid;
    logic [9:0]   cdb_tag;
    logic [1:0]   fu_ready;
    logic         flush;
    logic [1:0]   issue_valid;
    logic [9:0]   issue_rob_id;
    logic [127:0] issue_payload;
    logic [3:0]   occupancy;

    int checks = 0;
    int errors = 0;

    issue_queue #(.SS(2), .DEPTH(8), .NUM_ISSUE(2), .NUM_CDB(2), .ROB_ID_W(5),
                  .PAYLOAD_W(64), .TYPE_W(2), .FU_TYPE(2'd0)) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_type(disp_type), .disp_rob_id(disp_rob_id),
        .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy),
        .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy),
        .disp_payload(disp_payload), .disp_stall(disp_stall),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .fu_ready(fu_ready), .flush(flush),
        .issue_valid(issue_valid), .issue_rob_id(issue_rob_id),
        .issue_payload(issue_payload), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = '0;
        cdb_valid  = '0;
        flush      = 1'b0;
    endtask

    task automatic lane(input int k, input logic [1:0] ty, input logic [4:0] rob,
                        input logic [4:0] t1, input logic r1,
                        input logic [4:0] t2, input logic r2);
        disp_valid[k]          = 1'b1;
        disp_type[k*2 +: 2]    = ty;
        disp_rob_id[k*5 +: 5]  = rob;
        disp_src1_tag[k*5 +: 5] = t1;
        disp_src1_rdy[k]       = r1;
        disp_src2_tag[k*5 +: 5] = t2;
        disp_src2_rdy[k]       = r2;
        disp_payload[k*64 +: 64] = 64'hC0DE_0000_0000_0000 | 64'(rob);
    endtask

    task automatic rdy_op(input int k, input logic [4:0] rob);
        lane(k, 2'd0, rob, 5'd0, 1'b1, 5'd0, 1'b1);
    endtask

    task automatic cdb(input int c, input logic [4:0] tag);
        cdb_valid[c]      = 1'b1;
        cdb_tag[c*5 +: 5] = tag;
    endtask

    initial begin
        rst = 1'b1;
        disp_type = '0; disp_rob_id = '0; disp_src1_tag = '0; disp_src2_tag = '0;
        disp_src1_rdy = '0; disp_src2_rdy = '0; disp_payload = '0; cdb_tag = '0;
        fu_ready = 2'b00;
        idle();
        tick(); tick();
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_ivalid", 64'(issue_valid), 64'd0);
        chk("rst_stall", 64'(disp_stall), 64'd0);
        rst = 1'b0;

        // 1: ready op, single-cycle minimum latency
        fu_ready = 2'b11;
        rdy_op(0, 5'd3);
        tick(); idle();
        chk("t1_occ1", 64'(occupancy), 64'd1);
        chk("t1_noissue_c1", 64'(issue_valid), 64'd0);
        tick();
        chk("t1_ivalid", 64'(issue_valid), 64'b01);
        chk("t1_rob", 64'(issue_rob_id[4:0]), 64'd3);
        chk("t1_payload", issue_payload[63:0], 64'hC0DE_0000_0000_0003);
        chk("t1_occ0", 64'(occupancy), 64'd0);

        // 2: src1 waits for tag 9, broadcast on bus 1 in cycle 3
        lane(0, 2'd0, 5'd4, 5'd9, 1'b0, 5'd0, 1'b1);
        tick(); idle();
        chk("t2_occ", 64'(occupancy), 64'd1);
        tick();
        chk("t2_wait_c2", 64'(issue_valid), 64'd0);
        tick();
        cdb(1, 5'd9);
        chk("t2_wait_c3", 64'(issue_valid), 64'd0);
        tick(); idle();
        chk("t2_wait_c4", 64'(issue_valid), 64'd0);
        tick();
        chk("t2_ivalid_c5", 64'(issue_valid), 64'b01);
        chk("t2_rob", 64'(issue_rob_id[4:0]), 64'd4);

        // 3: same-cycle bypass; lane 0 has the wrong FU class and is ignored
        lane(0, 2'd1, 5'd6, 5'd0, 1'b1, 5'd0, 1'b1);
        lane(1, 2'd0, 5'd5, 5'd0, 1'b1, 5'd7, 1'b0);
        cdb(0, 5'd7);
        tick(); idle();
        chk("t3_occ_type_filter", 64'(occupancy), 64'd1);
        tick();
        chk("t3_ivalid", 64'(issue_valid), 64'b01);
        chk("t3_rob", 64'(issue_rob_id[4:0]), 64'd5);
        chk("t3_occ0", 64'(occupancy), 64'd0);

        // 4: fill all eight entries with FUs blocked, then drain oldest first
        fu_ready = 2'b00;
        rdy_op(0, 5'd10); rdy_op(1, 5'd11);
        tick();
        chk("t4_occ2", 64'(occupancy), 64'd2);
        rdy_op(0, 5'd12); rdy_op(1, 5'd13);
        tick();
        rdy_op(0, 5'd14); rdy_op(1, 5'd15);
        tick();
        chk("t4_occ6", 64'(occupancy), 64'd6);
        chk("t4_stall_occ6", 64'(disp_stall), 64'd0);
        rdy_op(0, 5'd16); rdy_op(1, 5'd17);
        tick();
        chk("t4_occ8", 64'(occupancy), 64'd8);
        chk("t4_stall_occ8", 64'(disp_stall), 64'd1);
        rdy_op(0, 5'd20); rdy_op(1, 5'd21);
        tick(); idle();
        chk("t4_stalled_drop", 64'(occupancy), 64'd8);
        chk("t4_noissue", 64'(issue_valid), 64'd0);
        fu_ready = 2'b01;
        tick();
        chk("t4_p0_only", 64'(issue_valid), 64'b01);
        chk("t4_rob10", 64'(issue_rob_id[4:0]), 64'd10);
        chk("t4_occ7", 64'(occupancy), 64'd7);
        chk("t4_stall_occ7", 64'(disp_stall), 64'd1);
        fu_ready = 2'b11;
        tick();
        chk("t4_d1_valid", 64'(issue_valid), 64'b11);
        chk("t4_d1_rob", 64'(issue_rob_id), 64'({5'd12, 5'd11}));
        tick();
        chk("t4_d2_rob", 64'(issue_rob_id), 64'({5'd14, 5'd13}));
        tick();
        chk("t4_d3_rob", 64'(issue_rob_id), 64'({5'd16, 5'd15}));
        chk("t4_d3_occ", 64'(occupancy), 64'd1);
        tick();
        chk("t4_d4_valid", 64'(issue_valid), 64'b01);
        chk("t4_d4_rob", 64'(issue_rob_id[4:0]), 64'd17);
        chk("t4_d4_occ", 64'(occupancy), 64'd0);
        tick();
        chk("t4_empty", 64'(issue_valid), 64'd0);

        // 5: age order decoupled from entry index (Z reuses entry 0)
        fu_ready = 2'b00;
        rdy_op(0, 5'd25); rdy_op(1, 5'd1);
        tick(); idle();
        fu_ready = 2'b01;
        rdy_op(0, 5'd2);
        tick(); idle();
        chk("t5_p_issue", 64'(issue_valid), 64'b01);
        chk("t5_p_rob", 64'(issue_rob_id[4:0]), 64'd25);
        chk("t5_occ2", 64'(occupancy), 64'd2);
        fu_ready = 2'b00;
        rdy_op(0, 5'd27);
        tick(); idle();
        chk("t5_occ3", 64'(occupancy), 64'd3);
        chk("t5_hold_valid", 64'(issue_valid), 64'd0);
        chk("t5_hold_rob", 64'(issue_rob_id[4:0]), 64'd25);
        fu_ready = 2'b01;
        tick();
        chk("t5_x_valid", 64'(issue_valid), 64'b01);
        chk("t5_x_rob", 64'(issue_rob_id[4:0]), 64'd1);
        fu_ready = 2'b11;
        tick();
        chk("t5_yz_valid", 64'(issue_valid), 64'b11);
        chk("t5_yz_rob", 64'(issue_rob_id), 64'({5'd27, 5'd2}));
        chk("t5_occ0", 64'(occupancy), 64'd0);

        // 6: flush with five entries and a same-cycle dispatch
        fu_ready = 2'b00;
        rdy_op(0, 5'd1); rdy_op(1, 5'd2);
        tick();
        rdy_op(0, 5'd3); rdy_op(1, 5'd4);
        tick(); idle();
        rdy_op(0, 5'd5);
        tick(); idle();
        chk("t6_occ5", 64'(occupancy), 64'd5);
        fu_ready = 2'b11;
        flush = 1'b1;
        rdy_op(0, 5'd9);
        tick(); idle();
        chk("t6_flush_occ", 64'(occupancy), 64'd0);
        chk("t6_flush_ivalid", 64'(issue_valid), 64'd0);
        chk("t6_flush_stall", 64'(disp_stall), 64'd0);
        tick();
        chk("t6_flush_c2", 64'(issue_valid), 64'd0);
        tick();
        chk("t6_flush_c3", 64'(issue_valid), 64'd0);

        // 6b: reset mid-run with eligible entries and ready FUs
        fu_ready = 2'b00;
        rdy_op(0, 5'd12); rdy_op(1, 5'd13);
        tick(); idle();
        chk("t6_rst_pre_occ", 64'(occupancy), 64'd2);
        fu_ready = 2'b11;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_occ", 64'(occupancy), 64'd0);
        chk("t6_rst_ivalid", 64'(issue_valid), 64'd0);
        chk("t6_rst_rob", 64'(issue_rob_id), 64'd0);
        tick();
        chk("t6_rst_after", 64'(issue_valid), 64'd0);
        chk("t6_rst_after_occ", 64'(occupancy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
